// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use bubbles, branch flushes,
// memory-busy freeze, E-stage forwarding selects and a saturating stall-cycle counter.
//
// state  | meaning
// IDLE   | no bubble pending; load-use detect is live
// LSTALL | inserting the 2nd..LOAD_LATENCY-th bubble of a load-use hazard; cnt = bubbles left
module hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int WB_SEL_W     = 2,
   parameter int WB_SEL_LOAD  = 0,
   parameter int LOAD_LATENCY = 1,
   parameter int PERF_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [REG_AW-1:0]   rs1_addr_D,
   input  logic [REG_AW-1:0]   rs2_addr_D,
   input  logic [REG_AW-1:0]   rs1_addr_E,
   input  logic [REG_AW-1:0]   rs2_addr_E,
   input  logic [REG_AW-1:0]   rd_E,
   input  logic [WB_SEL_W-1:0] sel_wb_E,
   input  logic                reg_write_E,
   input  logic [REG_AW-1:0]   rd_M,
   input  logic                reg_write_M,
   input  logic [REG_AW-1:0]   rd_W,
   input  logic                reg_write_W,
   input  logic                pc_src_E,
   input  logic                mem_busy,
   input  logic                perf_clr,
   output logic                stallF,
   output logic                stallD,
   output logic                stallE,
   output logic                stallM,
   output logic                flushD,
   output logic                flushE,
   output logic                flushW,
   output logic [1:0]          fwd_a_E,
   output logic [1:0]          fwd_b_E,
   output logic [PERF_W-1:0]   stall_cycles
);

   localparam int CNT_W = (LOAD_LATENCY + 1 > 1) ? $clog2(LOAD_LATENCY + 1) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LSTALL = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               lu;
   logic               stall_f;
   logic               stall_d;
   logic               stall_e;
   logic               stall_m;
   logic               flush_d;
   logic               flush_e;
   logic               flush_w;
   logic [1:0]         fwd_a;
   logic [1:0]         fwd_b;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rd_m,
      input logic              we_m,
      input logic [REG_AW-1:0] rd_w,
      input logic              we_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (we_m && (rd_m != '0) && (rd_m == rs))
         sel = 2'b10;
      else if (we_w && (rd_w != '0) && (rd_w == rs))
         sel = 2'b01;
      return sel;
   endfunction

   assign lu = reg_write_E
             && (sel_wb_E == WB_SEL_W'(WB_SEL_LOAD))
             && (rd_E != '0)
             && ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));

   // Priority: reset > memory busy > taken branch > pending bubbles > new load-use.
   always_comb begin
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_w   = 1'b0;
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
      state_nxt = state;
      cnt_nxt   = cnt;
      if (rst_n) begin
         fwd_a = fwd_sel(rs1_addr_E, rd_M, reg_write_M, rd_W, reg_write_W);
         fwd_b = fwd_sel(rs2_addr_E, rd_M, reg_write_M, rd_W, reg_write_W);
         if (mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (pc_src_E) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else if (state == LSTALL) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (LOAD_LATENCY > 1) begin
               state_nxt = LSTALL;
               cnt_nxt   = CNT_W'(LOAD_LATENCY - 1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (perf_clr)
         stall_cycles <= '0;
      else if (stall_f && (stall_cycles != {PERF_W{1'b1}}))
         stall_cycles <= stall_cycles + PERF_W'(1);
   end

   assign stallF  = stall_f;
   assign stallD  = stall_d;
   assign stallE  = stall_e;
   assign stallM  = stall_m;
   assign flushD  = flush_d;
   assign flushE  = flush_e;
   assign flushW  = flush_w;
   assign fwd_a_E = fwd_a;
   assign fwd_b_E = fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LATENCY=1/PERF_W=32 and
// LOAD_LATENCY=3/PERF_W=4) share stimulus and are checked against a bubble-count model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
   logic [4:0] rd_E, rd_M, rd_W;
   logic [1:0] sel_wb_E;
   logic       reg_write_E, reg_write_M, reg_write_W;
   logic       pc_src_E, mem_busy, perf_clr;

   logic        sF1, sD1, sE1, sM1, fD1, fE1, fW1;
   logic [1:0]  fa1, fb1;
   logic [31:0] cyc1;
   logic        sF3, sD3, sE3, sM3, fD3, fE3, fW3;
   logic [1:0]  fa3, fb3;
   logic [3:0]  cyc3;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_LATENCY(1), .PERF_W(32)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
      .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
      .rd_E(rd_E), .sel_wb_E(sel_wb_E), .reg_write_E(reg_write_E),
      .rd_M(rd_M), .reg_write_M(reg_write_M),
      .rd_W(rd_W), .reg_write_W(reg_write_W),
      .pc_src_E(pc_src_E), .mem_busy(mem_busy), .perf_clr(perf_clr),
      .stallF(sF1), .stallD(sD1), .stallE(sE1), .stallM(sM1),
      .flushD(fD1), .flushE(fE1), .flushW(fW1),
      .fwd_a_E(fa1), .fwd_b_E(fb1), .stall_cycles(cyc1));

   hazard_ctrl #(.LOAD_LATENCY(3), .PERF_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
      .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
      .rd_E(rd_E), .sel_wb_E(sel_wb_E), .reg_write_E(reg_write_E),
      .rd_M(rd_M), .reg_write_M(reg_write_M),
      .rd_W(rd_W), .reg_write_W(reg_write_W),
      .pc_src_E(pc_src_E), .mem_busy(mem_busy), .perf_clr(perf_clr),
      .stallF(sF3), .stallD(sD3), .stallE(sE3), .stallM(sM3),
      .flushD(fD3), .flushE(fE3), .flushW(fW3),
      .fwd_a_E(fa3), .fwd_b_E(fb3), .stall_cycles(cyc3));

   typedef struct {
      logic [10:0] ctrl1;
      logic [10:0] ctrl3;
      longint      cnt1;
      longint      cnt3;
      int          idx;
   } exp_t;

   exp_t   sb[$];
   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_cycle  = 0;

   // Model state: bubbles still owed after the current one, and stall-cycle totals.
   int     owe1 = 0, owe3 = 0;
   longint tot1 = 0, tot3 = 0;

   function automatic logic [1:0] fwd_model(input logic [4:0] rs);
      if (reg_write_M && rd_M != 0 && rd_M == rs) return 2'b10;
      if (reg_write_W && rd_W != 0 && rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   // ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, fwd_a, fwd_b}
   function automatic void model_step(input int ll, input int w, input logic lu,
                                      input int owe_in, input longint tot_in,
                                      output logic [10:0] ctrl,
                                      output int owe_out, output longint tot_out);
      logic sf, sd, se, sm, fd, fe, fw;
      longint maxv;
      {sf, sd, se, sm, fd, fe, fw} = 7'b0;
      maxv    = (longint'(1) << w) - 1;
      owe_out = owe_in;
      tot_out = tot_in;
      ctrl    = '0;
      if (!rst_n) begin
         owe_out = 0;
         tot_out = 0;
         return;
      end
      if (mem_busy) begin
         sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (pc_src_E) begin
         fd = 1; fe = 1;
         owe_out = 0;
      end else if (owe_in > 0) begin
         sf = 1; sd = 1; fe = 1;
         owe_out = owe_in - 1;
      end else if (lu) begin
         sf = 1; sd = 1; fe = 1;
         owe_out = ll - 1;
      end
      if (perf_clr) tot_out = 0;
      else if (sf && tot_in < maxv) tot_out = tot_in + 1;
      ctrl = {sf, sd, se, sm, fd, fe, fw, fwd_model(rs1_addr_E), fwd_model(rs2_addr_E)};
   endfunction

   task automatic push_expect();
      exp_t   e;
      logic   lu;
      int     o1, o3;
      longint t1, t3;
      lu = reg_write_E && sel_wb_E == 2'd0 && rd_E != 0 &&
           (rd_E == rs1_addr_D || rd_E == rs2_addr_D);
      e.cnt1 = rst_n ? tot1 : 0;
      e.cnt3 = rst_n ? tot3 : 0;
      model_step(1, 32, lu, owe1, tot1, e.ctrl1, o1, t1);
      model_step(3, 4,  lu, owe3, tot3, e.ctrl3, o3, t3);
      e.idx = n_cycle;
      sb.push_back(e);
      owe1 = o1; owe3 = o3; tot1 = t1; tot3 = t3;
      n_cycle++;
   endtask

   task automatic tick();
      push_expect();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
      rd_E = 0; sel_wb_E = 2'd1; reg_write_E = 0;
      rd_M = 0; reg_write_M = 0; rd_W = 0; reg_write_W = 0;
      pc_src_E = 0; mem_busy = 0; perf_clr = 0;
   endtask

   task automatic load_e(input logic [4:0] rd);
      reg_write_E = 1; sel_wb_E = 2'd0; rd_E = rd;
   endtask

   task automatic check(input string name, input int idx, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, idx, got, exp);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("ctrl_ll1", e.idx, longint'({sF1, sD1, sE1, sM1, fD1, fE1, fW1, fa1, fb1}), longint'(e.ctrl1));
         check("ctrl_ll3", e.idx, longint'({sF3, sD3, sE3, sM3, fD3, fE3, fW3, fa3, fb3}), longint'(e.ctrl3));
         check("perf_ll1", e.idx, longint'(cyc1), e.cnt1);
         check("perf_ll3", e.idx, longint'(cyc3), e.cnt3);
      end
   end

   initial begin
      set_idle();
      rst_n = 0;
      @(posedge clk);
      #1;
      // reset holds outputs low even with a hazard, a branch and forwarding present
      load_e(5); rs1_addr_D = 5; pc_src_E = 1;
      rd_M = 7; reg_write_M = 1; rs1_addr_E = 7;
      tick(); tick();
      set_idle(); rst_n = 1; tick();

      // single load-use, then E becomes a bubble
      load_e(5); rs1_addr_D = 5; tick();
      set_idle(); repeat (4) tick();

      // load-use with two busy cycles mid-window
      load_e(5); rs2_addr_D = 5; tick();
      set_idle(); tick();
      mem_busy = 1; tick(); tick();
      mem_busy = 0; repeat (4) tick();

      // x0 and non-load destinations never stall
      load_e(0); rs1_addr_D = 0; tick();
      reg_write_E = 1; sel_wb_E = 2'd1; rd_E = 6; rs1_addr_D = 6; tick();
      set_idle(); tick();

      // branch wins over a same-cycle load-use
      load_e(5); rs1_addr_D = 5; pc_src_E = 1; tick();
      set_idle(); tick();

      // branch on the 2nd bubble aborts the window; a fresh hazard is then detected
      load_e(5); rs1_addr_D = 5; tick();
      set_idle(); pc_src_E = 1; tick();
      pc_src_E = 0; load_e(9); rs2_addr_D = 9; tick();
      set_idle(); repeat (3) tick();

      // forwarding priority and x0 exclusion
      rd_M = 7; rd_W = 7; reg_write_M = 1; reg_write_W = 1; rs1_addr_E = 7; rs2_addr_E = 7; tick();
      reg_write_M = 0; tick();
      reg_write_M = 1; rd_M = 0; tick();
      rd_M = 3; rs2_addr_E = 3; tick();
      set_idle(); tick();

      // saturation of the narrow counter, then clear
      mem_busy = 1; repeat (20) tick();
      mem_busy = 0; perf_clr = 1; tick();
      perf_clr = 0; tick(); tick();

      // reset in the middle of a stall window
      load_e(5); rs1_addr_D = 5; tick();
      set_idle(); rst_n = 0; load_e(4); rs1_addr_D = 4; tick(); tick();
      set_idle(); rst_n = 1; tick(); tick();

      // randomized traffic on a small register range so matches are frequent
      for (int i = 0; i < 600; i++) begin
         rs1_addr_D  = 5'($urandom_range(0, 3));
         rs2_addr_D  = 5'($urandom_range(0, 3));
         rs1_addr_E  = 5'($urandom_range(0, 3));
         rs2_addr_E  = 5'($urandom_range(0, 3));
         rd_E        = 5'($urandom_range(0, 3));
         rd_M        = 5'($urandom_range(0, 3));
         rd_W        = 5'($urandom_range(0, 3));
         sel_wb_E    = 2'($urandom_range(0, 2));
         reg_write_E = ($urandom_range(0, 3) != 0);
         reg_write_M = $urandom_range(0, 1) == 1;
         reg_write_W = $urandom_range(0, 1) == 1;
         mem_busy    = ($urandom_range(0, 99) < 15);
         pc_src_E    = ($urandom_range(0, 99) < 10);
         perf_clr    = ($urandom_range(0, 99) < 3);
         rst_n       = ($urandom_range(0, 99) != 0);
         tick();
      end
      set_idle(); rst_n = 1; tick();

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
